// File: rtl/pcieifc_fifo_pkg.sv
// Shared helpers for both sides of the PCIe interface async FIFO: pointer
// width and Gray/binary conversion. Narrower pointers are zero-extended and truncated at the call site.
package pcieifc_fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic int ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros from zero-extension leave the low bits unaffected.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = gray;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/pcieifc_sync2.sv
// Width-parameterized two-flop synchronizer into the clk domain, with a
// synchronous active-high reset to zero.
module pcieifc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages sample the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pcieifc_fifo_rd_ctrl.sv
// Read-side controller of the PCIe async FIFO with a first-word-fall-through output stage.
// Optional almost-empty flag: define PCIEIFC_FIFO_RD_AEMPTY_EN.
module pcieifc_fifo_rd_ctrl
    import pcieifc_fifo_pkg::*;
#(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr_gray,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [DATASIZE-1:0] rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
    ,
    output logic                raempty
`endif
);

    localparam int PTR_W = ptr_width(ADDRSIZE);

    logic [PTR_W-1:0]    rq2_wptr;
    logic [PTR_W-1:0]    rq2_wbin;
    logic                pop;

    logic [PTR_W-1:0]    rbin_q,      rbin_d;
    logic [PTR_W-1:0]    rptr_gray_q, rptr_gray_d;
    logic                rempty_q,    rempty_d;
    logic [PTR_W-1:0]    rlevel_q,    rlevel_d;
    logic                rd_valid_q,  rd_valid_d;
    logic [DATASIZE-1:0] rd_data_q,   rd_data_d;
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
    logic                raempty_q,   raempty_d;
`endif

    pcieifc_sync2 #(
        .WIDTH (PTR_W)
    ) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr_gray),
        .q   (rq2_wptr)
    );

    assign rq2_wbin = PTR_W'(gray2bin(GRAY_MAX_W'(rq2_wptr)));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rbin_d     = rbin_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;

        // The output stage reloads whenever it is empty or being drained this cycle.
        pop = !rempty_q && (!rd_valid_q || rd_ready);
        if (pop) begin
            rbin_d     = rbin_q + PTR_W'(1);
            rd_data_d  = mem_rdata;
            rd_valid_d = 1'b1;
        end else if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        // Flags look at the post-pop pointer so the draining pop sets rempty on its own edge.
        rptr_gray_d = PTR_W'(bin2gray(GRAY_MAX_W'(rbin_d)));
        rempty_d    = (rptr_gray_d == rq2_wptr);
        rlevel_d    = rq2_wbin - rbin_d;
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
        raempty_d   = (rlevel_d <= PTR_W'(AEMPTY_THRESH));
`endif
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            rempty_q    <= 1'b1;
            rlevel_q    <= '0;
            rd_valid_q  <= 1'b0;
            // NOTE: the data register is reset too, since a held word must be discarded on reset.
            rd_data_q   <= '0;
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
            raempty_q   <= 1'b1;
`endif
        end else begin
            rbin_q      <= rbin_d;
            rptr_gray_q <= rptr_gray_d;
            rempty_q    <= rempty_d;
            rlevel_q    <= rlevel_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
            raempty_q   <= raempty_d;
`endif
        end
    end

    assign raddr     = rbin_q[ADDRSIZE-1:0];
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rptr_gray = rptr_gray_q;
    assign rempty    = rempty_q;
    assign rlevel    = rlevel_q;
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
    assign raempty   = raempty_q;
`endif

endmodule

// File: tb/tb_pcieifc_fifo_rd_ctrl.sv
// Self-checking bench for pcieifc_fifo_rd_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a word-queue reference model.
module tb_pcieifc_fifo_rd_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int PW  = AW + 1;
    localparam int THR = 2;

    logic          rclk = 1'b0;
    logic          rrst;
    logic [PW-1:0] wptr_gray;
    logic [AW-1:0] raddr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [PW-1:0] rptr_gray;
    logic          rempty;
    logic [PW-1:0] rlevel;
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
    logic          raempty;
`endif

    always #5 rclk = ~rclk;

    // Write side model: memory array plus a count of words written.
    logic [DW-1:0] mem [16];
    int            wr_total;
    logic [PW-1:0] wbin_v;
    logic [DW-1:0] exp_q[$];

    assign wbin_v    = wr_total[PW-1:0];
    assign wptr_gray = wbin_v ^ (wbin_v >> 1);
    assign mem_rdata = mem[raddr];

    pcieifc_fifo_rd_ctrl #(
        .DATASIZE      (DW),
        .ADDRSIZE      (AW),
        .AEMPTY_THRESH (THR)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .wptr_gray (wptr_gray),
        .raddr     (raddr),
        .mem_rdata (mem_rdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rptr_gray (rptr_gray),
        .rempty    (rempty),
        .rlevel    (rlevel)
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
        ,
        .raempty   (raempty)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_total[AW-1:0]] = d;
        exp_q.push_back(d);
        wr_total++;
    endtask

    task automatic do_reset(input int cycles);
        rrst     = 1'b1;
        rd_ready = 1'b0;
        wr_total = 0;
        exp_q.delete();
        repeat (cycles) tick();
        rrst = 1'b0;
    endtask

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = b[PW-1:0];
        return v ^ (v >> 1);
    endfunction

    typedef struct {
        bit            push;
        logic [DW-1:0] wdata;
        bit            ready;
        bit            exp_valid;
        logic [DW-1:0] exp_data;
        bit            exp_empty;
        logic [PW-1:0] exp_level;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t          tbl[10];
        int            gray_seq[6];
        int            nvalid;
        int            first;
        logic [AW-1:0] pre_addr;
        int            h1, h2, h3, rb, exp_lvl, acc_total;
        logic [PW-1:0] prev_gray;
        bit            held;
        logic [DW-1:0] held_data;
        logic [DW-1:0] e;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 5'd0};
        tbl[4] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b1, 5'd0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 5'd0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 5'd1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b1, 5'd0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0};
        gray_seq = '{0, 1, 3, 2, 6, 7};

        for (int i = 0; i < 16; i++) mem[i] = 8'(8'hE0 + i);

        // Reset state.
        do_reset(3);
        check("reset_rempty",    32'(rempty),    32'd1);
        check("reset_rlevel",    32'(rlevel),    32'd0);
        check("reset_rd_valid",  32'(rd_valid),  32'd0);
        check("reset_rd_data",   32'(rd_data),   32'd0);
        check("reset_rptr_gray", 32'(rptr_gray), 32'd0);
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
        check("reset_raempty",   32'(raempty),   32'd1);
`endif

        // Latency, hold and single-cycle reload, table-driven.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].push) push_word(tbl[i].wdata);
            rd_ready = tbl[i].ready;
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
            check($sformatf("tbl%0d_empty", i), 32'(rempty), 32'(tbl[i].exp_empty));
            check($sformatf("tbl%0d_level", i), 32'(rlevel), 32'(tbl[i].exp_level));
        end

        // Five words streamed with rd_ready held high.
        do_reset(2);
        check("stream_gray_start", 32'(rptr_gray), 32'(gray_seq[0]));
        rd_ready = 1'b1;
        nvalid   = 0;
        first    = -1;
        for (int c = 0; c < 14; c++) begin
            if (c < 5) push_word(8'(16 + c));
            pre_addr = raddr;
            tick();
            if (rd_valid) begin
                if (nvalid < 5) begin
                    check("stream_data",  32'(rd_data),   32'(16 + nvalid));
                    check("stream_raddr", 32'(pre_addr),  32'(nvalid));
                    check("stream_gray",  32'(rptr_gray), 32'(gray_seq[nvalid + 1]));
                    if (nvalid == 0) first = c;
                    else check("stream_consecutive", 32'(c), 32'(first + nvalid));
                    if (nvalid == 4) check("stream_empty_after_5th", 32'(rempty), 32'd1);
                end
                nvalid++;
            end
        end
        check("stream_count", 32'(nvalid), 32'd5);

        // Reset while a word is held and three remain in memory.
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            push_word(8'(8'h20 + k));
            tick();
        end
        repeat (6) tick();
        check("midrst_pre_valid", 32'(rd_valid), 32'd1);
        check("midrst_pre_level", 32'(rlevel),   32'd3);
        check("midrst_pre_data",  32'(rd_data),  32'h20);
        rrst     = 1'b1;
        wr_total = 0;
        exp_q.delete();
        tick();
        check("midrst_valid", 32'(rd_valid),  32'd0);
        check("midrst_level", 32'(rlevel),    32'd0);
        check("midrst_empty", 32'(rempty),    32'd1);
        check("midrst_gray",  32'(rptr_gray), 32'd0);
        check("midrst_raddr", 32'(raddr),     32'd0);
        tick();
        rrst = 1'b0;
        push_word(8'h77);
        repeat (4) tick();
        check("postrst_valid", 32'(rd_valid),  32'd1);
        check("postrst_data",  32'(rd_data),   32'h77);
        check("postrst_gray",  32'(rptr_gray), 32'd1);

`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
        // Almost-empty across a fill to 4 and a drain.
        do_reset(2);
        check("aempty_reset", 32'(raempty), 32'd1);
        for (int k = 0; k < 5; k++) begin
            push_word(8'(8'h40 + k));
            tick();
        end
        repeat (6) tick();
        check("aempty_fill_level", 32'(rlevel),  32'd4);
        check("aempty_fill_flag",  32'(raempty), 32'd0);
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("aempty_drain_level", 32'(rlevel),  32'(3 - k));
            check("aempty_drain_flag",  32'(raempty), 32'((3 - k) <= THR));
        end
`endif

        // Randomized traffic against the word-queue model.
        do_reset(2);
        h1 = 0; h2 = 0; h3 = 0;
        acc_total = 0;
        prev_gray = '0;
        held      = 1'b0;
        held_data = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            rb      = acc_total + int'(rd_valid);
            exp_lvl = h3 - rb;
            check("rand_level", 32'(rlevel),    32'(exp_lvl[PW-1:0]));
            check("rand_empty", 32'(rempty),    32'(exp_lvl == 0));
            check("rand_gray",  32'(rptr_gray), 32'(to_gray(rb)));
            check("rand_raddr", 32'(raddr),     32'(rb[AW-1:0]));
`ifdef PCIEIFC_FIFO_RD_AEMPTY_EN
            check("rand_aempty", 32'(raempty), 32'(exp_lvl <= THR));
`endif
            if (rptr_gray != prev_gray)
                check("rand_gray_onebit", 32'($countones(rptr_gray ^ prev_gray)), 32'd1);
            prev_gray = rptr_gray;
            if (held) check("rand_hold", 32'(rd_data), 32'(held_data));

            if (cyc >= 900)      rd_ready = 1'b1;
            else if (cyc < 300)  rd_ready = ($urandom_range(0, 3) == 0);
            else                 rd_ready = ($urandom_range(0, 3) != 0);
            if (cyc < 900 && (wr_total - acc_total) < 16 && $urandom_range(0, 2) != 0)
                push_word(8'($urandom_range(0, 255)));

            if (rd_valid && rd_ready) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else                  e = ~rd_data;
                check("rand_data_order", 32'(rd_data), 32'(e));
                acc_total++;
            end
            held      = rd_valid && !rd_ready;
            held_data = rd_data;
            h3 = h2; h2 = h1; h1 = wr_total;
            tick();
        end
        check("rand_all_drained", 32'(exp_q.size()), 32'd0);
        check("rand_acc_total",   32'(acc_total),    32'(wr_total));
        check("rand_enough_words", 32'(wr_total >= 40), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pcieifc_fifo_rd_ctrl.md
# pcieifc_fifo_rd_ctrl

Read-side controller for the PCIe interface asynchronous FIFO, the consumer end of the write-side dual-port FIFO memory. Owns the Gray-coded read pointer, synchronizes the write pointer into the read domain, and computes `rempty` and the fill level. Drives the memory's combinational read address and registers the returned word into a first-word-fall-through valid/ready output stage that sustains one word per cycle.

## Interface
- `DATASIZE`, 8, memory word width
- `ADDRSIZE`, 4, memory address bits; pointers are ADDRSIZE+1 bits
- `AEMPTY_THRESH`, 2, almost-empty threshold in words; used only when the almost-empty feature is compiled in
- `rclk` in 1: read-domain clock; the block's single clock
- `rrst` in 1: reset; synchronous and active-high
- `wptr_gray` in ADDRSIZE+1: write-domain Gray pointer; asynchronous to `rclk`
- `raddr` out ADDRSIZE: read address to the FIFO memory
- `mem_rdata` in DATASIZE: combinational read data from the FIFO memory at `raddr`
- `rd_data` out DATASIZE: output word
- `rd_valid` out 1: `rd_data` is valid
- `rd_ready` in 1: consumer accepts `rd_data`
- `rptr_gray` out ADDRSIZE+1: registered Gray read pointer, sent to the write domain
- `rempty` out 1: memory holds no unread word; the output register is excluded
- `rlevel` out ADDRSIZE+1: words in memory not yet popped; the output register is excluded
- `raempty` out 1: almost-empty flag; exists only with `PCIEIFC_FIFO_RD_AEMPTY_EN`

## Operation
- Binary read pointer `rbin` is ADDRSIZE+1 bits.
  - `raddr = rbin[ADDRSIZE-1:0]`.
  - `rptr_gray = rbin ^ (rbin >> 1)`, registered.
- Write-pointer synchronizer: 2 flops, giving `rq2_wptr`. Its Gray value is converted to binary `rq2_wbin`.
- Pop condition: `pop = !rempty && (!rd_valid || rd_ready)`.
- On pop:
  - `rd_data <= mem_rdata`
  - `rd_valid <= 1`
  - `rbin <= rbin + 1`, modulo 2^(ADDRSIZE+1)
- With no pop, if `rd_valid && rd_ready`, then `rd_valid <= 0`.
- Next-state flag and level, from next-state values:
  - `rempty <= (next rptr_gray == rq2_wptr)`
  - `rlevel <= rq2_wbin - next rbin`, modulo 2^(ADDRSIZE+1)
  - Invariant: `rempty == (rlevel == 0)` at all times.
- `rd_ready` is ignored while `rd_valid` is low.
- `rd_data` is held stable while `rd_valid && !rd_ready`.
- Pointer wrap: the MSB toggles every 2^ADDRSIZE pops. The Gray code changes exactly 1 bit per increment, including the wrap from all-ones to 0.
- The write side guarantees `wptr_gray` changes at most 1 bit per write-side update. This block trusts that and does no checking.

## Timing
- Values after reset:
  - `rbin = 0`, `rptr_gray = 0`, both synchronizer stages = 0
  - `rempty = 1`, `rlevel = 0`
  - `rd_valid = 0`, `rd_data = 0`
  - `raempty = 1`
- Write-pointer latency: a `wptr_gray` change captured at edge N:
  - `rq2_wptr` updates at N+1.
  - `rempty` falls and `rlevel` updates at N+2.
  - `rd_valid` rises at N+3 if the output stage was empty.
- Read latency: the pop edge loads `rd_data`, which is visible the same cycle that `rd_valid` is high. Zero bubble.
- Throughput: `rd_valid && rd_ready && !rempty` pops and reloads on the same edge, giving 1 word/cycle.
- Last word: the pop that drains memory sets `rempty = 1` on the same edge, and `rd_valid` stays high until accepted.
- Reset mid-operation: all state returns to reset values on the next `rclk` edge with `rrst` high, and any held output word is discarded. The write side must be reset in the same system reset window.
- Gray compare and level are computed from registered values only. There is no combinational path from `wptr_gray` to any output.

## Configuration
- `PCIEIFC_FIFO_RD_AEMPTY_EN` defined:
  - `raempty` port exists.
  - `raempty <= (next rlevel <= AEMPTY_THRESH)`, updated on the same edge as `rlevel`.
  - Reset value 1.
- Not defined:
  - The `raempty` port and its logic are absent.
  - `AEMPTY_THRESH` is unused.

## Structure
- Shared package `pcieifc_fifo_pkg`:
  - `bin2gray` and `gray2bin` functions, parameterized by width
  - Pointer-width localparam helper (ADDRSIZE+1)
  - Shared by this block and the write-side controller
- Sub-module `pcieifc_sync2`:
  - Width-parameterized 2-flop synchronizer on `rclk`
  - Synchronous active-high reset to 0
  - The write side reuses it in the opposite direction.

## Test plan
- Reset with `wptr_gray=0`, hold `rrst` 3 cycles → `rempty=1`, `rlevel=0`, `rd_valid=0`, `rd_data=0`, `rptr_gray=0`.
- Set `wptr_gray` 0→1 at edge N, `mem_rdata=8'hA5`, `rd_ready=0` → `rempty=0` at N+2, `rd_valid=1` and `rd_data=8'hA5` at N+3, `rempty=1` and `rlevel=0` at N+3, `rd_data` held while `rd_ready` stays low.
- Write pointer at 5, `rd_ready=1` continuously → 5 consecutive valid cycles, `raddr` 0..4, `rptr_gray` sequence 0,1,3,2,6,7, `rempty` high after the 5th pop.
- Stream 40 words with ADDRSIZE=4 → `rbin` wraps at 32, MSB toggles at pops 16 and 32, every `rptr_gray` step changes exactly 1 bit, no word lost or duplicated.
- Assert `rrst` while `rd_valid=1` and `rlevel=3` → next edge `rd_valid=0`, `rlevel=0`, `rempty=1`; the next write is read from address 0.
- With `PCIEIFC_FIFO_RD_AEMPTY_EN` and `AEMPTY_THRESH=2`, fill to 4 and drain → `raempty=0` at `rlevel` 4 and 3, 1 at `rlevel` 2, 1 and 0.
